pipe_skid_buffer: RTL and testbench
===================================

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_W, 96, datapath payload width (alu_out, mem_data, sext/pc fields packed).
- CTRL_W, 8, control-bit width; all control bits are zero in a NOP.
- TAG_W, 10, register-index width (rs2, rd packed).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, squashes every held entry and the current input.
- in_valid, input, 1, upstream stage offers an entry.
- in_ready, output, 1, block can accept an entry.
- in_ctrl, input, CTRL_W, upstream control bits.
- in_tag, input, TAG_W, upstream register indices.
- in_data, input, DATA_W, upstream datapath payload.
- out_valid, output, 1, downstream entry present.
- out_ready, input, 1, downstream accepts; low means stall.
- out_ctrl, output, CTRL_W, downstream control bits.
- out_tag, output, TAG_W, downstream register indices.
- out_data, output, DATA_W, downstream payload.
- stall_cnt, output, 32, stall counter; present only with PIPE_SKID_PERF_EN.

Function
REQ-003 The block SHALL hold at most two entries (main, skid) in FIFO order; out_* SHALL always present the main entry.
REQ-004 States SHALL be EMPTY (0 entries), ONE (main only) and FULL (main+skid).
REQ-005 in_ready SHALL be a registered signal, equal to 1 in EMPTY and ONE and 0 in FULL.
REQ-006 Transfer-in SHALL occur when in_valid && in_ready; transfer-out SHALL occur when out_valid && out_ready.
REQ-007 Latency from transfer-in to out_valid SHALL be exactly 1 cycle when the block is EMPTY.
REQ-008 Transitions SHALL be as follows:
- EMPTY->ONE on transfer-in.
- ONE->EMPTY on transfer-out without transfer-in.
- ONE stays ONE on simultaneous transfer-in and transfer-out.
- ONE->FULL on transfer-in without transfer-out.
- FULL->ONE on transfer-out; the skid entry moves to main.
REQ-009 Simultaneous transfer-in and transfer-out in ONE SHALL replace main with the input in the same cycle, with no bubble.
REQ-010 While out_ready=0, out_ctrl, out_tag and out_data SHALL remain stable.
REQ-011 When out_valid=0, out_ctrl and out_tag SHALL be all-zero (NOP); out_data SHALL hold its last value.
REQ-012 flush SHALL take priority over every other event: the next state is EMPTY, both entries' ctrl and tag are zeroed, and the input of that cycle is discarded.
REQ-013 flush with in_valid=0 or out_ready=0 SHALL behave identically to REQ-012.
REQ-014 in_valid while in_ready=0 SHALL be ignored; upstream holds it.

Reset
REQ-015 On rst_n low, the block SHALL immediately enter EMPTY with out_valid=0, in_ready=0, out_ctrl=0, out_tag=0, out_data=0, skid contents=0 and stall_cnt=0.
REQ-016 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-017 An assertion of rst_n mid-transfer SHALL discard all entries, with no partial update.

Configuration
REQ-018 With PIPE_SKID_PERF_EN defined:
- stall_cnt SHALL increment by 1 each cycle out_valid && !out_ready.
- stall_cnt SHALL saturate at 32'hFFFF_FFFF.
- stall_cnt SHALL be unaffected by flush.
REQ-019 Without PIPE_SKID_PERF_EN, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-020 Package pipe_pkg SHALL hold:
- the state enum typedef (EMPTY, ONE, FULL);
- the CTRL_NOP constant;
- the default width constants.
REQ-021 Each entry SHALL be an instance of sub-module pipe_entry_reg (valid, ctrl, tag, data register with load and clear).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single entry: in ctrl=8'h15, tag=10'h0A3, data=96'h1 with out_ready=1 -> out_valid=1 next cycle with identical fields; EMPTY after the following cycle.
- Back-to-back: 4 entries (data 1..4) on consecutive cycles with out_ready=1 -> outputs 1..4 on consecutive cycles; in_ready stays 1.
- Stall: out_ready=0 while sending data 7, 8, 9 -> FULL after 7, 8; in_ready=0; 9 held upstream. After out_ready=1, order 7, 8, 9 with no loss.
- Flush in FULL with simultaneous in_valid (data 5) -> next cycle out_valid=0, out_ctrl=0, out_tag=0; data 5 never appears.
- Reset mid-stall (FULL, rst_n low 1 cycle) -> all outputs 0 immediately; in_ready=1 one edge after release.
- PIPE_SKID_PERF_EN: 10 stall cycles -> stall_cnt=10. A flush during the stall leaves the count unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid buffer.
//
// Contents:
//   - Default payload, control and tag widths.
//   - CTRL_NOP: the control encoding of a bubble. All control bits are zero.
//   - skid_state_e: buffer occupancy (empty, main only, main plus skid).
package pipe_pkg;

  localparam int unsigned DataWDef = 96;
  localparam int unsigned CtrlWDef = 8;
  localparam int unsigned TagWDef  = 10;

  localparam logic [CtrlWDef-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffer slot: valid flag plus control, tag and payload registers.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset (all fields to zero)
//   clear_i         drop the entry: valid=0, ctrl/tag to NOP; payload keeps its value
//   load_i          capture ctrl_i/tag_i/data_i and mark the entry valid
//   ctrl_i, tag_i, data_i   values to capture
//   valid_o, ctrl_o, tag_o, data_o   current contents
// clear_i wins over load_i.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned CTRL_W = CtrlWDef,
  parameter int unsigned TAG_W  = TagWDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o
);

  localparam logic [CTRL_W-1:0] CtrlNop = CTRL_W'(CTRL_NOP);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
  logic [TAG_W-1:0]  tag_d,   tag_q;
  logic [DATA_W-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = CtrlNop;
      tag_d   = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      tag_d   = tag_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CtrlNop;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer between pipeline stages. in_ready comes straight from a flop,
// so upstream sees no combinational path from out_ready.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           squash both entries and the current input
//   in_valid/in_ready               upstream handshake (in_ready is registered)
//   in_ctrl, in_tag, in_data        upstream entry
//   out_valid/out_ready             downstream handshake
//   out_ctrl, out_tag, out_data     head (main) entry; ctrl/tag are NOP when empty
//   stall_cnt                       saturating count of out_valid && !out_ready cycles
//                                   (only when PIPE_SKID_PERF_EN is defined)
//
// Optional feature macro: PIPE_SKID_PERF_EN adds the stall_cnt port and counter.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned CTRL_W = CtrlWDef,
  parameter int unsigned TAG_W  = TagWDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  skid_state_e state_d, state_q;
  logic        in_ready_q;

  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
  logic [TAG_W-1:0]  skid_tag,  main_tag_in;
  logic [DATA_W-1:0] skid_data, main_data_in;
  logic              xfer_in, xfer_out;

  assign xfer_in  = in_valid && in_ready_q;
  assign xfer_out = main_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = StEmpty;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (xfer_in) begin
            main_load = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          // Simultaneous in/out overwrites main directly: no bubble.
          if (xfer_in && xfer_out) begin
            main_load = 1'b1;
          end else if (xfer_in) begin
            skid_load = 1'b1;
            state_d   = StFull;
          end else if (xfer_out) begin
            main_clear = 1'b1;
            state_d    = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only the skid-to-main promotion can happen.
          if (xfer_out && skid_valid) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = StOne;
          end
        end
        default: begin
          state_d    = StEmpty;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_tag_in  = main_from_skid ? skid_tag  : in_tag;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .TAG_W  (TAG_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (main_clear),
    .load_i  (main_load),
    .ctrl_i  (main_ctrl_in),
    .tag_i   (main_tag_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (out_ctrl),
    .tag_o   (out_tag),
    .data_o  (out_data)
  );

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .TAG_W  (TAG_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (skid_clear),
    .load_i  (skid_load),
    .ctrl_i  (in_ctrl),
    .tag_i   (in_tag),
    .data_i  (in_data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .tag_o   (skid_tag),
    .data_o  (skid_data)
  );

  assign out_valid = main_valid;
  assign in_ready  = in_ready_q;

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_cnt_q;

  // Counts regardless of flush; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (main_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed scenarios followed by random traffic, all checked
// against a queue-based model of the buffer's contents.
module tb_pipe_skid_buffer;

  localparam int unsigned DW = 96;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 10;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [TW-1:0] out_tag;
  logic [DW-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  pipe_skid_buffer #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .TAG_W  (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_tag   (out_tag),
    .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic          m_ready;
  logic [DW-1:0] m_last_data;
  logic [31:0]   m_stall;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready     = 1'b0;
    m_last_data = '0;
    m_stall     = '0;
  endtask

  task automatic compare_all();
    check_val("out_valid", out_valid, mq.size() > 0);
    check_val("in_ready", in_ready, m_ready);
    check_val("out_ctrl", out_ctrl, (mq.size() > 0) ? mq[0].ctrl : '0);
    check_val("out_tag", out_tag, (mq.size() > 0) ? mq[0].tag : '0);
    check_val("out_data", out_data, (mq.size() > 0) ? mq[0].data : m_last_data);
`ifdef PIPE_SKID_PERF_EN
    check_val("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  // One clock edge: advance the model with the inputs the DUT sampled, then compare.
  task automatic step();
    ent_t e;
    @(posedge clk);
    if (mq.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (flush) begin
      mq.delete();
    end else begin
      logic take_out, take_in;
      take_out = (mq.size() > 0) && out_ready;
      take_in  = in_valid && m_ready;
      if (take_out) void'(mq.pop_front());
      if (take_in) begin
        e.ctrl = in_ctrl;
        e.tag  = in_tag;
        e.data = in_data;
        mq.push_back(e);
      end
    end
    m_ready = (mq.size() < 2);
    if (mq.size() > 0) m_last_data = mq[0].data;
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [TW-1:0] t,
                       input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_tag   = t;
    in_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    model_reset();
    #2;
    compare_all();
    #10 rst_n = 1'b1;
    step();
    check_val("rst_release_in_ready", in_ready, 1'b1);

    // Single entry.
    out_ready = 1'b1;
    drive(1'b1, 8'h15, 10'h0A3, 96'h1);
    step();
    check_val("single_valid", out_valid, 1'b1);
    check_val("single_ctrl", out_ctrl, 8'h15);
    check_val("single_tag", out_tag, 10'h0A3);
    check_val("single_data", out_data, 96'h1);
    drive(1'b0, '0, '0, '0);
    step();
    check_val("single_empty", out_valid, 1'b0);

    // Back-to-back.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i + 1), 10'(i * 3), 96'(i));
      step();
      check_val("b2b_data", out_data, 128'(i));
      check_val("b2b_in_ready", in_ready, 1'b1);
    end
    drive(1'b0, '0, '0, '0);
    step();

    // Stall with 7, 8 buffered, 9 held upstream.
    out_ready = 1'b0;
    drive(1'b1, 8'h07, 10'h007, 96'd7);
    step();
    drive(1'b1, 8'h08, 10'h008, 96'd8);
    step();
    check_val("stall_full_in_ready", in_ready, 1'b0);
    drive(1'b1, 8'h09, 10'h009, 96'd9);
    step();
    check_val("stall_hold_data", out_data, 96'd7);
    out_ready = 1'b1;
    step();
    check_val("stall_order_8", out_data, 96'd8);
    step();
    check_val("stall_order_9", out_data, 96'd9);
    drive(1'b0, '0, '0, '0);
    step();
    check_val("stall_drained", out_valid, 1'b0);

    // Flush in FULL with an input offered alongside.
    out_ready = 1'b0;
    drive(1'b1, 8'h0A, 10'h00A, 96'hA);
    step();
    drive(1'b1, 8'h0B, 10'h00B, 96'hB);
    step();
    flush = 1'b1;
    drive(1'b1, 8'h05, 10'h005, 96'd5);
    step();
    check_val("flush_valid", out_valid, 1'b0);
    check_val("flush_ctrl", out_ctrl, 8'h00);
    check_val("flush_tag", out_tag, 10'h000);
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("flush_no_5", out_valid, 1'b0);
    end

    // Reset while FULL and stalled.
    out_ready = 1'b0;
    drive(1'b1, 8'h21, 10'h021, 96'h21);
    step();
    drive(1'b1, 8'h22, 10'h022, 96'h22);
    step();
    drive(1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check_val("rst_out_data_zero", out_data, 96'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check_val("rst_mid_in_ready", in_ready, 1'b1);

`ifdef PIPE_SKID_PERF_EN
    // Ten stall cycles, then a flush that must not disturb the count.
    out_ready = 1'b0;
    drive(1'b1, 8'h31, 10'h031, 96'h31);
    step();
    drive(1'b0, '0, '0, '0);
    repeat (10) step();
    check_val("perf_stall_10", stall_cnt, 32'd10);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    check_val("perf_after_flush", stall_cnt, 32'd10);
    flush = 1'b0;
    step();
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      drive(($urandom_range(0, 9) < 6), 8'($urandom), 10'($urandom),
            {$urandom, $urandom, $urandom});
      step();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end

endmodule
